cmem_mailbox: RTL

- Parametrised successor to the shared command-memory block.
- Dual-ported mailbox register file between the SPI (Raspberry) side and the CP (Amiga) side.
- Adds cross-side event/enable interrupt logic: RASP_IRQ toward the Pi, INT2 drive toward the Amiga.
- Generalised in data width, register count and event width. New over the previous generation: IRQ mode selection, and no event loss on simultaneous set/clear.

---
 rtl/cmem_mailbox.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cmem_mailbox.sv
// cmem_mailbox: dual-ported mailbox register file between the SPI (Pi) side
// and the CP (Amiga) side, with cross-side event/enable interrupt logic.
//
// Address map (N = 2**ADDR_W):
//   0..N-5  data registers, read/write from both sides, CP wins a write clash
//   N-4     r_events  : CP writes 1s to set, SPI read returns and clears
//   N-3     r_enable  : SPI owned
//   N-2     a_events  : SPI writes 1s to set, CP read returns and clears
//   N-1     a_enable  : CP owned
//
// Optional feature macro: CMEM_MAILBOX_BLOCK_TIMEOUT_EN
//   defined   -> INT2 drive is blocked after 2**TIMEOUT_W-1 cycles of drive
//                until the CP reads a_events
//   undefined -> no timeout counter; INT2 follows (a_events & a_enable) != 0
module cmem_mailbox #(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 4,
    parameter int R_EN_RST    = 7,
    parameter int A_EN_RST    = 3,
    parameter int R_IRQ_LEVEL = 0,
    parameter int TIMEOUT_W   = 28
) (
    input  logic              clk200,
    input  logic              reset,
    input  logic              spi_read,
    input  logic              spi_write,
    input  logic [ADDR_W-1:0] spi_address,
    input  logic [DATA_W-1:0] spi_out_cmem_in,
    output logic [DATA_W-1:0] spi_in_cmem_out,
    input  logic              cp_read,
    input  logic              cp_write,
    input  logic [ADDR_W-1:0] cp_address,
    input  logic [DATA_W-1:0] cp_out_cmem_in,
    output logic [DATA_W-1:0] cp_in_cmem_out,
    output logic              RASP_IRQ,
    output logic              int2_drive
);

    localparam int N     = 2 ** ADDR_W;
    localparam int NDATA = N - 4;

    localparam logic [ADDR_W-1:0] ADDR_REV = ADDR_W'(N - 4);
    localparam logic [ADDR_W-1:0] ADDR_REN = ADDR_W'(N - 3);
    localparam logic [ADDR_W-1:0] ADDR_AEV = ADDR_W'(N - 2);
    localparam logic [ADDR_W-1:0] ADDR_AEN = ADDR_W'(N - 1);

    localparam logic [DATA_W-1:0] R_EN_RST_V = DATA_W'(R_EN_RST);
    localparam logic [DATA_W-1:0] A_EN_RST_V = DATA_W'(A_EN_RST);

    // Elaboration-time sanity on the parameter set
    generate
        if (ADDR_W < 3) begin : g_bad_addr_w
            $error("cmem_mailbox: ADDR_W must be at least 3");
        end
        if (TIMEOUT_W < 2) begin : g_bad_timeout_w
            $error("cmem_mailbox: TIMEOUT_W must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [NDATA];
    logic [DATA_W-1:0] r_events_q, r_events_d;
    logic [DATA_W-1:0] r_enable_q, r_enable_d;
    logic [DATA_W-1:0] a_events_q, a_events_d;
    logic [DATA_W-1:0] a_enable_q, a_enable_d;
    logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;
    logic [DATA_W-1:0] cp_rdata_q, cp_rdata_d;
    logic              rasp_irq_q;
    logic              r_armed_q;
    logic              int2_q;

    // ------------------------------------------------------------------
    // Strobe decode
    // ------------------------------------------------------------------
    logic spi_wr_data, cp_wr_data;
    logic spi_rd_rev, cp_wr_rev, spi_wr_ren;
    logic spi_wr_aev, cp_rd_aev, cp_wr_aen;
    logic r_trig, a_should;

    assign spi_wr_data = spi_write && (spi_address < ADDR_REV);
    assign cp_wr_data  = cp_write  && (cp_address  < ADDR_REV);
    assign spi_rd_rev  = spi_read  && (spi_address == ADDR_REV);
    assign cp_wr_rev   = cp_write  && (cp_address  == ADDR_REV);
    assign spi_wr_ren  = spi_write && (spi_address == ADDR_REN);
    assign spi_wr_aev  = spi_write && (spi_address == ADDR_AEV);
    assign cp_rd_aev   = cp_read   && (cp_address  == ADDR_AEV);
    assign cp_wr_aen   = cp_write  && (cp_address  == ADDR_AEN);

    // Next-state of the event/enable registers; a set in the same cycle as
    // a read-clear wins so no event is ever dropped
    always_comb begin
        r_events_d = r_events_q;
        if (cp_wr_rev) begin
            r_events_d = spi_rd_rev ? cp_out_cmem_in : (r_events_q | cp_out_cmem_in);
        end else if (spi_rd_rev) begin
            r_events_d = '0;
        end

        a_events_d = a_events_q;
        if (spi_wr_aev) begin
            a_events_d = cp_rd_aev ? spi_out_cmem_in : (a_events_q | spi_out_cmem_in);
        end else if (cp_rd_aev) begin
            a_events_d = '0;
        end

        r_enable_d = spi_wr_ren ? spi_out_cmem_in : r_enable_q;
        a_enable_d = cp_wr_aen  ? cp_out_cmem_in  : a_enable_q;
    end

    // Read muxes: data registers give the old value, event registers
    // bypass a same-cycle set so the reader sees it before it is cleared
    always_comb begin
        spi_rdata_d = '0;
        if (spi_address < ADDR_REV) begin
            spi_rdata_d = mem_q[spi_address];
        end else if (spi_address == ADDR_REV) begin
            spi_rdata_d = r_events_q | (cp_wr_rev ? cp_out_cmem_in : '0);
        end else if (spi_address == ADDR_REN) begin
            spi_rdata_d = r_enable_q;
        end

        cp_rdata_d = '0;
        if (cp_address < ADDR_REV) begin
            cp_rdata_d = mem_q[cp_address];
        end else if (cp_address == ADDR_AEV) begin
            cp_rdata_d = a_events_q | (spi_wr_aev ? spi_out_cmem_in : '0);
        end else if (cp_address == ADDR_AEN) begin
            cp_rdata_d = a_enable_q;
        end
    end

    // Data registers: unreset; CP write is applied last so it wins a clash
    always_ff @(posedge clk200) begin
        if (!reset) begin
            if (spi_wr_data) begin
                mem_q[spi_address] <= spi_out_cmem_in;
            end
            if (cp_wr_data) begin
                mem_q[cp_address] <= cp_out_cmem_in;
            end
        end
    end

    // Control registers and registered read ports
    always_ff @(posedge clk200) begin
        if (reset) begin
            r_events_q  <= '0;
            a_events_q  <= '0;
            r_enable_q  <= R_EN_RST_V;
            a_enable_q  <= A_EN_RST_V;
            spi_rdata_q <= '0;
            cp_rdata_q  <= '0;
        end else begin
            r_events_q <= r_events_d;
            a_events_q <= a_events_d;
            r_enable_q <= r_enable_d;
            a_enable_q <= a_enable_d;
            if (spi_read) begin
                spi_rdata_q <= spi_rdata_d;
            end
            if (cp_read) begin
                cp_rdata_q <= cp_rdata_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pi-side interrupt
    // ------------------------------------------------------------------
    assign r_trig = |(r_events_d & r_enable_d);

    // Toggle mode: one edge per armed trigger, re-armed by reading r_events
    // (re-arm beats a coincident trigger, which then fires next cycle as the
    // event is still pending). Level mode: registered trigger.
    always_ff @(posedge clk200) begin
        if (reset) begin
            rasp_irq_q <= 1'b0;
            r_armed_q  <= 1'b1;
        end else if (R_IRQ_LEVEL != 0) begin
            rasp_irq_q <= r_trig;
            r_armed_q  <= 1'b1;
        end else if (spi_rd_rev) begin
            r_armed_q <= 1'b1;
        end else if (r_armed_q && r_trig) begin
            rasp_irq_q <= ~rasp_irq_q;
            r_armed_q  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Amiga-side INT2 drive with optional block timeout
    // ------------------------------------------------------------------
    logic a_block_d;

`ifdef CMEM_MAILBOX_BLOCK_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic                 a_block_q;

    // Count drive cycles; wrapping to zero blocks further drive. The block
    // takes effect on the same edge so drive lasts 2**TIMEOUT_W-1 cycles.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        a_block_d = a_block_q;
        if (cp_rd_aev) begin
            blk_cnt_d = TIMEOUT_W'(1);
            a_block_d = 1'b0;
        end else if (int2_q) begin
            blk_cnt_d = blk_cnt_q + TIMEOUT_W'(1);
            if (blk_cnt_d == '0) begin
                a_block_d = 1'b1;
            end
        end
    end

    // Timeout counter and block flag
    always_ff @(posedge clk200) begin
        if (reset) begin
            blk_cnt_q <= TIMEOUT_W'(1);
            a_block_q <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            a_block_q <= a_block_d;
        end
    end
`else
    assign a_block_d = 1'b0;
`endif

    assign a_should = (|(a_events_d & a_enable_d)) && !a_block_d;

    // INT2 drive follows a_should with one cycle of latency
    always_ff @(posedge clk200) begin
        if (reset) begin
            int2_q <= 1'b0;
        end else begin
            int2_q <= a_should;
        end
    end

    assign spi_in_cmem_out = spi_rdata_q;
    assign cp_in_cmem_out  = cp_rdata_q;
    assign RASP_IRQ        = rasp_irq_q;
    assign int2_drive      = int2_q;

endmodule
